edge_event_reporter: RTL and testbench
======================================

# edge_event_reporter

Sits directly downstream of the edge detector stage and consumes its per-row result vector, one bit per pixel row, every clock. It debounces each row's hit bit, turns each qualified rising edge into one event record `{row, timestamp}`, and queues the records in a small FIFO. The FIFO drains through a valid/ready interface to the capture/logging logic. Rows that re-qualify before their previous event has been queued are merged and counted as drops.

## Interface
Parameters:
- `PIXEL_HEIGHT`, default 5: number of rows (width of `hits`).
- `HOLD`, default 2: consecutive hit cycles required to qualify a row (≥1).
- `FIFO_DEPTH`, default 4: event queue entries (power of two, ≥2).
- `TS_WIDTH`, default 16: timestamp width.
- `ROW_W`: derived, `$clog2(PIXEL_HEIGHT)`, minimum 1.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `hits`  in  PIXEL_HEIGHT  per-row detector result, bit i = row i, valid every cycle.
- `event_valid`  out  1  FIFO head holds an event.
- `event_ready`  in  1  consumer accepts the head.
- `event_row`  out  ROW_W  row index of the head event.
- `event_time`  out  TS_WIDTH  timestamp of the head event.
- `active`  out  PIXEL_HEIGHT  debounced row state.
- `dropped`  out  8  merged-event count, saturating at 255.

## Operation
- Time counter: `TS_WIDTH`-bit free-running counter. It increments every cycle and wraps modulo 2^TS_WIDTH.
- Per-row run counter: saturating, range 0..HOLD.
  - Increments when `hits[i]`=1.
  - Clears when `hits[i]`=0.
  - `active[i]` = (counter == HOLD).
- Qualification: row i qualifies in the cycle its counter goes from HOLD-1 to HOLD. A row can re-qualify only after a 0 followed by HOLD ones.
- On qualification, `pending[i]` is set.
  - If `pending[i]` is already set, the events merge and `dropped` increments (saturating).
  - Several rows may qualify in the same cycle.
- Push: each cycle where `pending`≠0 and the FIFO count < FIFO_DEPTH:
  - Push the lowest-index pending row with the current time counter value.
  - Clear that pending bit.
  - If the same row qualifies in the same cycle, the set wins over the clear: the bit stays set, and this is not a drop.
- Full FIFO: no push; pending bits hold; nothing is dropped.
- Pop: when `event_valid` && `event_ready`.
  - `event_row`/`event_time` show the head and stay stable while `event_valid`=1 and `event_ready`=0.
- Push and pop may occur in the same cycle when count < FIFO_DEPTH; count is then unchanged.
- At count == FIFO_DEPTH, push is blocked even if a pop occurs in the same cycle.

## Timing
Cycle n denotes the interval after the n-th rising edge following reset release; the time counter reads n in cycle n.
- Reset values:
  - Time counter, run counters, `pending`, FIFO pointers/count: 0.
  - `event_valid`=0, `active`=0, `dropped`=0.
  - `event_row`/`event_time` are don't-care while `event_valid`=0.
- Reset asserted mid-operation discards all queued and pending events; the state above holds in the cycle after the reset edge.
- Row i high in cycles n..n+HOLD-1:
  - `active[i]`=1 from cycle n+HOLD.
  - Push at the end of cycle n+HOLD with timestamp n+HOLD (FIFO not full, nothing lower pending).
  - `event_valid`=1 in cycle n+HOLD+1.
- Total latency, last required hit sample to `event_valid`: 2 cycles, best case.
- k rows qualifying together are pushed on k consecutive cycles with timestamps t, t+1, …, t+k-1.
- `active[i]` drops in the cycle after `hits[i]` is sampled 0.

## Test plan
- Single event (HOLD=2, `event_ready`=1): `hits[2]`=1 in cycles 3–4 → `active[2]`=1 in cycle 5; `event_valid`=1 in cycle 6 with row=2, time=5; `event_valid`=0 in cycle 7.
- Glitch reject: `hits[1]`=1 for cycle 3 only → `active` stays 0, no event, `dropped`=0.
- Simultaneous rows: rows 0, 3 and 4 high in cycles 10–11 → events row 0/time 12, row 3/time 13, row 4/time 14 on consecutive cycles.
- Backpressure and drops: `event_ready`=0; rows 0–4 qualify in cycles 5, 8, 11, 14, 17 → FIFO holds rows 0–3 and row 4 stays pending. Re-qualify row 4 → `dropped`=1. Raise `event_ready` → rows 0, 1, 2, 3, 4 drain in order, with row 4 exactly once.
- Reset mid-operation: two events queued and one pending, pulse `reset` → next cycle `event_valid`=0, `dropped`=0, time counter=0; no stale event appears afterward.
- Timestamp wrap (TS_WIDTH=4): qualify a row with the push in cycle 17 → `event_time`=1.

Source files
------------

// File: rtl/edge_event_reporter.sv
// edge_event_reporter
//   Debounces the per-row hit vector from the edge detector, converts each
//   qualified rising edge into a {row, timestamp} event and queues the events
//   in a small FIFO drained over valid/ready.
// Ports:
//   clock, reset   single clock, synchronous active-high reset
//   hits           per-row detector result, sampled every cycle
//   event_valid    FIFO head holds an event
//   event_ready    consumer accepts the head
//   event_row      row index of the head event
//   event_time     timestamp of the head event
//   active         debounced row state
//   dropped        saturating count of merged (re-qualified while pending) events

// Per-row debouncer: saturating run counter 0..HOLD.
module edge_event_row #(
  parameter int HOLD = 2,
  parameter int CW   = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic hit,
  output logic active,
  output logic qualify
);
  localparam logic [CW-1:0] FULL = CW'(HOLD);
  localparam logic [CW-1:0] PRE  = CW'(HOLD - 1);

  logic [CW-1:0] run;

  // Qualifies only on the HOLD-1 -> HOLD step, so a row must drop to 0
  // before it can qualify again.
  assign qualify = hit && (run == PRE);
  assign active  = (run == FULL);

  always_ff @(posedge clock) begin
    if (reset)          run <= '0;
    else if (!hit)      run <= '0;
    else if (run != FULL) run <= run + 1'b1;
  end
endmodule

module edge_event_reporter #(
  parameter int PIXEL_HEIGHT = 5,
  parameter int HOLD         = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int TS_WIDTH     = 16,
  localparam int ROW_W       = (PIXEL_HEIGHT > 1) ? $clog2(PIXEL_HEIGHT) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [PIXEL_HEIGHT-1:0] hits,
  output logic                    event_valid,
  input  logic                    event_ready,
  output logic [ROW_W-1:0]        event_row,
  output logic [TS_WIDTH-1:0]     event_time,
  output logic [PIXEL_HEIGHT-1:0] active,
  output logic [7:0]              dropped
);
  localparam int CW  = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [TS_WIDTH-1:0]     ts;
  logic [PIXEL_HEIGHT-1:0] qual, pending, pending_nxt, clr, drop;
  logic [ROW_W-1:0]        sel;
  logic [7:0]              dropped_nxt;

  logic [ROW_W-1:0]    row_mem [FIFO_DEPTH];
  logic [TS_WIDTH-1:0] ts_mem  [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                push, pop, full;

  for (genvar g = 0; g < PIXEL_HEIGHT; g++) begin : g_row
    edge_event_row #(.HOLD(HOLD), .CW(CW)) u_row (
      .clock   (clock),
      .reset   (reset),
      .hit     (hits[g]),
      .active  (active[g]),
      .qualify (qual[g])
    );
  end

  assign full        = (count == DEPTH_C);
  assign event_valid = (count != '0);
  assign pop         = event_valid && event_ready;
  // A pop in the same cycle does not free a slot for a push when full.
  assign push        = (pending != '0) && !full;
  assign event_row   = row_mem[rd_ptr];
  assign event_time  = ts_mem[rd_ptr];

  // Lowest pending row: priority encoder plus one-hot clear mask.
  always_comb begin
    sel = '0;
    for (int i = PIXEL_HEIGHT - 1; i >= 0; i--)
      if (pending[i]) sel = ROW_W'(i);
  end

  always_comb begin
    int ndrop;
    int sum;
    clr         = push ? (pending & (~pending + PIXEL_HEIGHT'(1))) : '0;
    // Set beats clear: a row re-qualifying as it is pushed stays pending
    // and is not a drop.
    drop        = qual & pending & ~clr;
    pending_nxt = (pending & ~clr) | qual;
    ndrop       = 0;
    for (int i = 0; i < PIXEL_HEIGHT; i++)
      if (drop[i]) ndrop++;
    sum         = int'(dropped) + ndrop;
    dropped_nxt = (sum > 255) ? 8'hFF : sum[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts      <= '0;
      pending <= '0;
      dropped <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      ts      <= ts + 1'b1;
      pending <= pending_nxt;
      dropped <= dropped_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read while counted valid.
  always_ff @(posedge clock) begin
    if (push) begin
      row_mem[wr_ptr] <= sel;
      ts_mem[wr_ptr]  <= ts;
    end
  end
endmodule

// File: tb/tb_edge_event_reporter.sv
module tb_edge_event_reporter;
  localparam int PH = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [PH-1:0] hits  = '0;
  logic          event_ready = 1'b1;
  logic          event_valid, w_valid;
  logic [2:0]    event_row, w_row;
  logic [15:0]   event_time;
  logic [3:0]    w_time;
  logic [PH-1:0] active, w_active;
  logic [7:0]    dropped, w_dropped;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  edge_event_reporter #(.PIXEL_HEIGHT(PH), .HOLD(2), .FIFO_DEPTH(4), .TS_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .hits(hits),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_row(event_row), .event_time(event_time),
    .active(active), .dropped(dropped)
  );

  // Same stimulus, 4-bit timestamp to exercise wrap.
  edge_event_reporter #(.PIXEL_HEIGHT(PH), .HOLD(2), .FIFO_DEPTH(4), .TS_WIDTH(4)) dut_w (
    .clock(clock), .reset(reset), .hits(hits),
    .event_valid(w_valid), .event_ready(event_ready),
    .event_row(w_row), .event_time(w_time),
    .active(w_active), .dropped(w_dropped)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge that starts cycle cyc.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic go(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  int exp_row [4] = '{1, 2, 3, 4};
  int exp_ts  [4] = '{8, 11, 14, 23};
  logic [PH-1:0] h;

  initial begin
    // ---- reset state + single event
    do_reset();
    chk("rst_valid", event_valid, 0);
    chk("rst_active", active, 0);
    chk("rst_dropped", dropped, 0);
    go(3); hits = 5'b00100;
    go(5); hits = 5'b00000;
    chk("single_active", active, 5'b00100);
    chk("single_valid_early", event_valid, 0);
    go(6);
    chk("single_valid", event_valid, 1);
    chk("single_row", event_row, 2);
    chk("single_time", event_time, 5);
    chk("single_active_off", active, 0);
    go(7);
    chk("single_valid_off", event_valid, 0);

    // ---- glitch reject
    go(10); hits = 5'b00010;
    go(11); hits = 5'b00000;
    for (int c = 11; c <= 14; c++) begin
      go(c);
      chk("glitch_active", active, 0);
      chk("glitch_valid", event_valid, 0);
    end
    chk("glitch_dropped", dropped, 0);

    // ---- simultaneous rows 0,3,4
    do_reset();
    go(10); hits = 5'b11001;
    go(12); hits = 5'b00000;
    chk("simul_active", active, 5'b11001);
    chk("simul_valid_early", event_valid, 0);
    go(13); chk("simul_row0", event_row, 0); chk("simul_t0", event_time, 12);
    go(14); chk("simul_row1", event_row, 3); chk("simul_t1", event_time, 13);
    go(15); chk("simul_row2", event_row, 4); chk("simul_t2", event_time, 14);
            chk("simul_valid2", event_valid, 1);
    go(16); chk("simul_valid_off", event_valid, 0);

    // ---- backpressure and drops
    do_reset();
    event_ready = 1'b0;
    while (cyc < 22) begin
      h = '0;
      for (int i = 0; i < 4; i++)
        if (cyc == 3*i + 3 || cyc == 3*i + 4) h[i] = 1'b1;
      if (cyc == 15 || cyc == 16 || cyc == 19 || cyc == 20) h[4] = 1'b1;
      hits = h;
      if (cyc == 17) chk("bp_active4", active, 5'b10000);
      if (cyc == 18) begin
        chk("bp_valid", event_valid, 1);
        chk("bp_head_row", event_row, 0);
        chk("bp_head_time", event_time, 5);
        chk("bp_dropped0", dropped, 0);
      end
      if (cyc == 21) begin
        chk("bp_dropped1", dropped, 1);
        chk("bp_head_row_stable", event_row, 0);
        chk("bp_head_time_stable", event_time, 5);
      end
      step();
    end
    hits = '0;
    chk("drain_row0", event_row, 0);
    chk("drain_t0", event_time, 5);
    event_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_valid", event_valid, 1);
      chk("drain_row", event_row, exp_row[k]);
      chk("drain_time", event_time, exp_ts[k]);
    end
    step(); chk("drain_empty", event_valid, 0);
    step(); chk("drain_empty2", event_valid, 0);
    chk("drain_dropped", dropped, 1);

    // ---- reset mid-operation (continues from the drained state, dropped=1)
    event_ready = 1'b0;
    go(31); hits = 5'b00111;
    go(33); hits = 5'b00000;
    go(35);
    chk("mid_valid", event_valid, 1);
    chk("mid_row", event_row, 0);
    chk("mid_time", event_time, 33);
    chk("mid_dropped", dropped, 1);
    do_reset();
    chk("mid_rst_valid", event_valid, 0);
    chk("mid_rst_dropped", dropped, 0);
    chk("mid_rst_active", active, 0);
    event_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      go(c);
      chk("mid_no_stale", event_valid, 0);
    end
    go(6); hits = 5'b01000;
    go(8); hits = 5'b00000;
    go(9);
    chk("mid_new_valid", event_valid, 1);
    chk("mid_new_row", event_row, 3);
    chk("mid_new_time", event_time, 8);

    // ---- timestamp wrap (4-bit instance)
    do_reset();
    go(15); hits = 5'b00001;
    go(17); hits = 5'b00000;
    go(18);
    chk("wrap_valid", w_valid, 1);
    chk("wrap_row", w_row, 0);
    chk("wrap_time", w_time, 1);
    chk("wrap_ref_time", event_time, 17);
    chk("wrap_dropped", w_dropped, 0);
    chk("wrap_active", w_active, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
